pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Instruction-fetch front end of the IF stage. It owns the program counter and drives the instruction memory address. It captures the returned instruction together with its PC into a small fetch queue, and hands entries to the IF/ID boundary through a valid/ready handshake. Taken-branch/jump redirects from later stages flush the queue and reload the PC.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `QUEUE_DEPTH`, default 2: fetch queue entries. Must be a power of two, ≥2.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `imem_addr`  out  32  fetch address to instruction memory `addr`.
- `imem_instr`  in  32  instruction returned combinationally for `imem_addr`.
- `redirect_valid`  in  1  taken branch/jump from EX; single-cycle pulse.
- `redirect_pc`  in  32  redirect target.
- `id_valid`  out  1  queue head valid toward decode.
- `id_ready`  in  1  decode accepts head this cycle.
- `id_instr`  out  32  head instruction.
- `id_pc`  out  32  head PC.
- `id_pc_plus4`  out  32  head PC + 4.
- `fetch_count`  out  32  retired-fetch counter. Present only with `PC_FETCH_PERF_CNT_EN`.

## Operation
- `fetch_pc` register. `imem_addr = fetch_pc` combinationally.
- Queue of {pc, instr} entries, with head/tail pointers and an occupancy count (0..QUEUE_DEPTH).
- Pop: `id_valid && id_ready` at a clock edge.
- Push: at a clock edge when `!redirect_valid` and (count < QUEUE_DEPTH or pop). The push writes {fetch_pc, imem_instr} at the tail and sets `fetch_pc <= fetch_pc + 4`.
- Full with no pop: no push, and `fetch_pc` holds, so the same address is re-presented.
- Push and pop in the same cycle: count unchanged.
- Redirect has priority over push and pop:
  - queue emptied (count=0, pointers reset);
  - `fetch_pc <= {redirect_pc[31:2], 2'b00}` (low bits forced to zero);
  - no push that cycle;
  - a head handshake in that cycle is discarded, not counted.
- Empty queue: `id_valid=0`, `id_instr=32'h0000_0013` (NOP), `id_pc=0`, `id_pc_plus4=0`.
- Non-empty queue: outputs are the head entry, muxed combinationally from storage. `id_pc_plus4` is computed mod 2^32.
- Arithmetic: all PC math is 32-bit and wraps; 32'hFFFF_FFFC + 4 = 0. Queue pointers wrap modulo QUEUE_DEPTH.
- Reset (asserting at any time, including mid-operation) takes effect immediately:
  - `fetch_pc=RESET_PC`, so `imem_addr=RESET_PC`;
  - queue empty, so `id_valid=0`, `id_instr=NOP`, `id_pc=0`, `id_pc_plus4=0`;
  - `fetch_count=0`.

## Timing
- Fetch latency: an address presented in cycle N appears at the head no earlier than cycle N+1, after the push edge.
- After reset release, the first rising edge pushes RESET_PC, and `id_valid=1` in the following cycle.
- Sustained throughput: one instruction per cycle with `id_ready=1`.
- Redirect at edge E: `id_valid=0` in cycle E+1 with `imem_addr` = the aligned target. The target is at the head in cycle E+2.
- Backpressure: `id_valid` and the head stay stable while `id_ready=0`. No entry is lost or duplicated.

## Configuration
- `PC_FETCH_PERF_CNT_EN` defined: adds the `fetch_count` port.
  - Increments by 1 on every non-redirect pop.
  - 32-bit, wraps, reset 0.
- Undefined: port and counter logic absent; behaviour otherwise identical.

## Structure
- Shared package `if_pkg` holds:
  - `NOP_INSTR = 32'h0000_0013`;
  - `XLEN = 32`;
  - typedef `fetch_entry_t` {pc[31:0], instr[31:0]}.
- One sub-module, `fetch_queue`: a parameterised FIFO with push/pop/flush, count, and a head output. `pc_fetch_unit` holds the PC, push/redirect control and the counter.

## Test plan
All scenarios use the IF instruction memory image: addr 0 = 32'h0021_8233 (add x4,x3,x2); addr 4 = 32'h0000_0013; other addresses = 0.
- Reset release, `id_ready=1`: heads in consecutive cycles are (pc 0, 32'h0021_8233, pc_plus4 4), then (4, 32'h0000_0013), then (8, 0).
- `id_ready=0` for 5 cycles after reset: count reaches 2 holding pc 0 and 4, `imem_addr` holds 8. After release, pcs 0, 4, 8 appear in order without gaps.
- With the queue full, pulse `redirect_valid` with `redirect_pc=32'h40`: next cycle `id_valid=0` and `imem_addr=32'h40`; the following cycle `id_pc=32'h40`, `id_instr=0`.
- `redirect_pc=32'h43`: `imem_addr` becomes 32'h40.
- Redirect to 32'hFFFF_FFFC with `id_ready=1`: the head after the target has `id_pc=0` and `id_pc_plus4=4`.
- Mid-stream async reset (drop `rst_n` between edges): `imem_addr=RESET_PC` and `id_valid=0` before the next edge. With `PC_FETCH_PERF_CNT_EN`, 3 accepted pops plus 1 pop coincident with a redirect give `fetch_count=3`.

Source files
------------

// File: rtl/if_pkg.sv
// Shared IF-stage definitions: data width, the NOP encoding and the
// {pc, instr} record carried through the fetch queue.
package if_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Power-of-two FIFO of fetched {pc, instr} records with push, pop, flush,
// an occupancy count and a combinational head view.
module fetch_queue
    import if_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [XLEN-1:0] push_pc,
    input  logic [XLEN-1:0] push_instr,
    input  logic            pop,
    input  logic            flush,
    output logic [PW:0]     count,
    output logic [XLEN-1:0] head_pc,
    output logic [XLEN-1:0] head_instr
);

    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] head_ptr;
    logic [PW-1:0] tail_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_COUNT) || do_pop);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else if (flush) begin
            head_ptr <= '0;
            tail_ptr <= '0;
            count    <= '0;
        end else begin
            if (do_push) tail_ptr <= tail_ptr + PW'(1);
            if (do_pop)  head_ptr <= head_ptr + PW'(1);
            if (do_push && !do_pop)      count <= count + (PW+1)'(1);
            else if (!do_push && do_pop) count <= count - (PW+1)'(1);
        end
    end

    // NOTE: storage is not reset; occupancy gates visibility, so stale slots are never observed.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[tail_ptr] <= '{pc: push_pc, instr: push_instr};
    end

    assign head_pc    = mem[head_ptr].pc;
    assign head_instr = mem[head_ptr].instr;

endmodule

// File: rtl/pc_fetch_unit.sv
// IF-stage front end: PC register, fetch queue control and redirect handling.
// Define PC_FETCH_PERF_CNT_EN to add the fetch_count port and counter.
module pc_fetch_unit
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          QUEUE_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
`ifdef PC_FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(QUEUE_DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   q_count;
    logic [XLEN-1:0] q_head_pc;
    logic [XLEN-1:0] q_head_instr;
    logic            q_push;
    logic            q_pop;

    assign imem_addr = fetch_pc;
    assign id_valid  = (q_count != '0);

    // A handshake coinciding with a redirect is dropped along with the flushed queue.
    assign q_pop  = id_valid && id_ready && !redirect_valid;
    assign q_push = !redirect_valid && ((q_count != FULL_COUNT) || q_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              fetch_pc <= RESET_PC;
        else if (redirect_valid) fetch_pc <= redirect_pc & ~32'h0000_0003;
        else if (q_push)         fetch_pc <= fetch_pc + 32'd4;
    end

    fetch_queue #(
        .DEPTH(QUEUE_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .push_pc   (fetch_pc),
        .push_instr(imem_instr),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .count     (q_count),
        .head_pc   (q_head_pc),
        .head_instr(q_head_instr)
    );

    // NOTE: every output gets a default first so always_comb never infers a latch.
    always_comb begin
        id_instr    = NOP_INSTR;
        id_pc       = '0;
        id_pc_plus4 = '0;
        if (id_valid) begin
            id_instr    = q_head_instr;
            id_pc       = q_head_pc;
            id_pc_plus4 = q_head_pc + 32'd4;
        end
    end

`ifdef PC_FETCH_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     fetch_count <= '0;
        else if (q_pop) fetch_count <= fetch_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed vector table, hand-written
// counter/async-reset sequence, and randomized run against a queue model.
module tb_pc_fetch_unit;
    import if_pkg::*;

    localparam int          D        = 2;
    localparam logic [31:0] RST_PC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b0;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
`ifdef PC_FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
`endif
    logic        hash_img = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .RESET_PC   (RST_PC),
        .QUEUE_DEPTH(D)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_pc_plus4   (id_pc_plus4)
`ifdef PC_FETCH_PERF_CNT_EN
        ,
        .fetch_count   (fetch_count)
`endif
    );

    // Instruction memory: the fixed IF image, or an address hash for random runs.
    function automatic logic [31:0] imem_word(input logic [31:0] a, input logic h);
        if (h) return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        if (a == 32'h0) return 32'h0021_8233;
        if (a == 32'h4) return 32'h0000_0013;
        return 32'h0;
    endfunction

    assign imem_instr = imem_word(imem_addr, hash_img);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model: a plain queue of fetched records plus the next fetch address.
    fetch_entry_t mq[$];
    logic [31:0]  mpc;
    logic [31:0]  mcnt;

    task automatic model_reset();
        mq.delete();
        mpc  = RST_PC;
        mcnt = '0;
    endtask

    // Enters and leaves at a falling edge, with rst_n released.
    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        id_ready       = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit          rst;
        bit          redir;
        logic [31:0] rpc;
        bit          rdy;
        bit          v;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[$];

    task automatic apply_vec(input vec_t t, input int idx);
        string s;
        if (t.rst) do_reset();
        redirect_valid = t.redir;
        redirect_pc    = t.rpc;
        id_ready       = t.rdy;
        #1;
        s = $sformatf("vec%0d", idx);
        check({s, ".valid"}, 32'(id_valid), 32'(t.v));
        check({s, ".addr"}, imem_addr, t.addr);
        check({s, ".pc"}, id_pc, t.v ? t.pc : 32'h0);
        check({s, ".instr"}, id_instr, t.v ? t.instr : NOP_INSTR);
        check({s, ".pc_plus4"}, id_pc_plus4, t.v ? t.pc + 32'd4 : 32'h0);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit r, input logic [31:0] rp, input bit rdy);
        redirect_valid = r;
        redirect_pc    = rp;
        id_ready       = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_step(input int i);
        bit          r;
        bit          rdy;
        bit          popd;
        int          sz;
        logic [31:0] rp;
        fetch_entry_t hd;
        r   = ($urandom_range(0, 11) == 0);
        rdy = ($urandom_range(0, 3) != 0);
        rp  = ($urandom_range(0, 2) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom;
        redirect_valid = r;
        redirect_pc    = rp;
        id_ready       = rdy;
        #1;
        hd = (mq.size() != 0) ? mq[0] : '{pc: 32'h0, instr: NOP_INSTR};
        check($sformatf("rnd%0d.valid", i), 32'(id_valid), 32'(mq.size() != 0));
        check($sformatf("rnd%0d.addr", i), imem_addr, mpc);
        check($sformatf("rnd%0d.pc", i), id_pc, hd.pc);
        check($sformatf("rnd%0d.instr", i), id_instr, hd.instr);
        check($sformatf("rnd%0d.pc_plus4", i), id_pc_plus4, (mq.size() != 0) ? hd.pc + 32'd4 : 32'h0);
`ifdef PC_FETCH_PERF_CNT_EN
        check($sformatf("rnd%0d.fetch_count", i), fetch_count, mcnt);
`endif
        @(posedge clk);
        if (r) begin
            mq.delete();
            mpc = {rp[31:2], 2'b00};
        end else begin
            sz   = mq.size();
            popd = (sz != 0) && rdy;
            if (popd) begin
                void'(mq.pop_front());
                mcnt++;
            end
            if (sz < D || popd) begin
                mq.push_back('{pc: mpc, instr: imem_word(mpc, hash_img)});
                mpc = mpc + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        // {rst, redir, rpc, rdy, exp valid, exp pc, exp instr, exp addr}
        vecs.push_back('{1, 0, 32'h0, 1, 0, 32'h0, 32'h0, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 1, 1, 32'h0, 32'h0021_8233, 32'h4});
        vecs.push_back('{0, 0, 32'h0, 1, 1, 32'h4, 32'h0000_0013, 32'h8});
        vecs.push_back('{0, 0, 32'h0, 1, 1, 32'h8, 32'h0, 32'hC});
        vecs.push_back('{1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 0, 1, 32'h0, 32'h0021_8233, 32'h4});
        vecs.push_back('{0, 0, 32'h0, 0, 1, 32'h0, 32'h0021_8233, 32'h8});
        vecs.push_back('{0, 0, 32'h0, 0, 1, 32'h0, 32'h0021_8233, 32'h8});
        vecs.push_back('{0, 0, 32'h0, 0, 1, 32'h0, 32'h0021_8233, 32'h8});
        vecs.push_back('{0, 0, 32'h0, 1, 1, 32'h0, 32'h0021_8233, 32'h8});
        vecs.push_back('{0, 0, 32'h0, 1, 1, 32'h4, 32'h0000_0013, 32'hC});
        vecs.push_back('{0, 0, 32'h0, 0, 1, 32'h8, 32'h0, 32'h10});
        vecs.push_back('{0, 1, 32'h40, 1, 1, 32'h8, 32'h0, 32'h10});
        vecs.push_back('{0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 32'h40});
        vecs.push_back('{0, 0, 32'h0, 1, 1, 32'h40, 32'h0, 32'h44});
        vecs.push_back('{0, 1, 32'h43, 1, 1, 32'h44, 32'h0, 32'h48});
        vecs.push_back('{0, 0, 32'h0, 1, 0, 32'h0, 32'h0, 32'h40});
        vecs.push_back('{0, 1, 32'hFFFF_FFFC, 1, 1, 32'h40, 32'h0, 32'h44});
        vecs.push_back('{0, 0, 32'h0, 1, 0, 32'h0, 32'h0, 32'hFFFF_FFFC});
        vecs.push_back('{0, 0, 32'h0, 1, 1, 32'hFFFF_FFFC, 32'h0, 32'h0});
        vecs.push_back('{0, 0, 32'h0, 1, 1, 32'h0, 32'h0021_8233, 32'h4});

        @(negedge clk);
        #1;
        check("reset.addr", imem_addr, RST_PC);
        check("reset.valid", 32'(id_valid), 32'h0);
        check("reset.instr", id_instr, NOP_INSTR);

        foreach (vecs[i]) apply_vec(vecs[i], i);

        // Three accepted pops, then a pop coinciding with a redirect.
        do_reset();
        drive(0, 32'h0, 1);
        drive(0, 32'h0, 1);
        drive(0, 32'h0, 1);
        drive(0, 32'h0, 1);
        drive(1, 32'h100, 1);
        redirect_valid = 1'b0;
        #1;
        check("cnt_seq.valid", 32'(id_valid), 32'h0);
        check("cnt_seq.addr", imem_addr, 32'h100);
`ifdef PC_FETCH_PERF_CNT_EN
        check("cnt_seq.fetch_count", fetch_count, 32'd3);
`endif
        @(negedge clk);
        drive(0, 32'h0, 0);
        drive(0, 32'h0, 0);

        // Asynchronous reset between edges must act before the next rising edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst.addr", imem_addr, RST_PC);
        check("async_rst.valid", 32'(id_valid), 32'h0);
        check("async_rst.instr", id_instr, NOP_INSTR);
        check("async_rst.pc", id_pc, 32'h0);
        check("async_rst.pc_plus4", id_pc_plus4, 32'h0);
`ifdef PC_FETCH_PERF_CNT_EN
        check("async_rst.fetch_count", fetch_count, 32'h0);
`endif
        @(negedge clk);

        hash_img = 1'b1;
        do_reset();
        for (int i = 0; i < 600; i++) rand_step(i);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
